semaforo_sequenciador: RTL and testbench
========================================

SEMAFORO_SEQUENCIADOR -- requirements
Module: semaforo_sequenciador

Interface
REQ-001 Parameter T_VERDE_MIN, default 8, minimum green duration in clk cycles (range 1..255).
REQ-002 Parameter T_AMARELO, default 3, yellow duration in clk cycles (range 1..255).
REQ-003 Parameter T_VERMELHO, default 2, all-red clearance duration in clk cycles (range 1..255).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge system clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 sa  input  1  request: street A wants green, from the upstream combinational Semaforo stage; synchronous to clk.
REQ-008 sb  input  1  request: street B wants green, same source and timing as sa.
REQ-009 verde_a, amarelo_a, vermelho_a  output  1 each  lamp drives, street A.
REQ-010 verde_b, amarelo_b, vermelho_b  output  1 each  lamp drives, street B.
REQ-011 fase  output  3  current FSM state code, for debug.

Function
REQ-012 The FSM SHALL have six states: VERDE_A, AMARELO_A, VERMELHO_AB, VERDE_B, AMARELO_B, VERMELHO_BA.
REQ-013 Outputs SHALL be Moore, decoded only from the state register, with exactly one lamp per street asserted every cycle.
REQ-014 Lamp map: VERDE_A gives A green, B red; AMARELO_A gives A yellow, B red; VERMELHO_AB and VERMELHO_BA give both red; VERDE_B gives B green, A red; AMARELO_B gives B yellow, A red.
REQ-015 An 8-bit dwell counter cnt SHALL clear to 0 on every state entry and increment once per cycle while in the state.
REQ-016 AMARELO_x SHALL last exactly T_AMARELO cycles, then advance to VERMELHO_AB or VERMELHO_BA respectively.
REQ-017 VERMELHO_AB SHALL last exactly T_VERMELHO cycles, then go to VERDE_B; VERMELHO_BA SHALL last exactly T_VERMELHO cycles, then go to VERDE_A.
REQ-018 In VERDE_A, cnt SHALL saturate at T_VERDE_MIN-1; the FSM SHALL leave for AMARELO_A only on an edge where cnt == T_VERDE_MIN-1 and sb=1 and sa=0.
REQ-019 VERDE_B SHALL behave symmetrically, leaving for AMARELO_B only on an edge where cnt == T_VERDE_MIN-1 and sa=1 and sb=0.
REQ-020 When sa=sb (both requesting or neither), the current green SHALL be held indefinitely; there is no starvation timeout.
REQ-021 Request inputs SHALL be ignored in AMARELO and VERMELHO states; a request that drops during yellow or red SHALL NOT abort the sequence.
REQ-022 A request pulse shorter than the remaining minimum green SHALL be lost; requests are not latched.
REQ-023 fase encoding SHALL be: VERDE_A=0, AMARELO_A=1, VERMELHO_AB=2, VERDE_B=3, AMARELO_B=4, VERMELHO_BA=5; codes 6 and 7 SHALL recover to VERMELHO_BA on the next edge.

Reset
REQ-024 rst=1 SHALL immediately force state VERMELHO_BA and cnt=0, giving vermelho_a=vermelho_b=1, all other lamps 0, and fase=5.
REQ-025 Reset asserted mid-sequence SHALL abandon the sequence; after release the FSM SHALL run VERMELHO_BA for T_VERMELHO cycles, then VERDE_A.

Structure
REQ-026 Package semaforo_pkg SHALL hold the state encoding and the default timing constants.
REQ-027 The dwell counter SHALL be a sub-module semaforo_timer with inputs clear and sat_en, a limit input, and outputs cnt and done.

Verification
REQ-028 Reset then sa=sb=0: fase=5 for 2 cycles, then fase=0 held indefinitely; verde_a=1 and vermelho_b=1 throughout the hold.
REQ-029 In VERDE_A with cnt saturated, drive sb=1, sa=0: next edge fase=1 for 3 cycles, fase=2 for 2 cycles, then fase=3.
REQ-030 Enter VERDE_A and drive sb=1 at cycle 0: the transition to AMARELO_A SHALL occur at the 8th edge of the green phase and no earlier.
REQ-031 In VERDE_B, drive sa=1 and sb=1: remains fase=3 for 50 or more cycles.
REQ-032 Assert rst during AMARELO_B: lamps go all-red asynchronously; after release, fase=5 for 2 cycles, then fase=0.
REQ-033 Every cycle of every test: exactly one lamp per street asserted, and never green on both streets simultaneously.

Source files
------------

// File: rtl/semaforo_pkg.sv
// semaforo_pkg: state encoding and default timing for the traffic-light sequencer
package semaforo_pkg;
  typedef enum logic [2:0] {
    VERDE_A     = 3'd0,
    AMARELO_A   = 3'd1,
    VERMELHO_AB = 3'd2,
    VERDE_B     = 3'd3,
    AMARELO_B   = 3'd4,
    VERMELHO_BA = 3'd5
  } fase_e;
  localparam int unsigned T_VERDE_MIN_DEF = 8;
  localparam int unsigned T_AMARELO_DEF   = 3;
  localparam int unsigned T_VERMELHO_DEF  = 2;
endpackage

// File: rtl/semaforo_timer.sv
// semaforo_timer: per-state dwell counter, cleared on state entry, optionally saturating
module semaforo_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       sat_en,
  input  logic [7:0] limit,
  output logic [7:0] cnt,
  output logic       done
);
  logic [7:0] cnt_q, cnt_d;
  assign done = cnt_q == limit;
  assign cnt  = cnt_q;
  always_comb cnt_d = clear ? 8'd0 : (sat_en && done) ? cnt_q : cnt_q + 8'd1;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
endmodule

// File: rtl/semaforo_sequenciador.sv
// semaforo_sequenciador: two-street traffic-light FSM with minimum green, yellow and all-red clearance
module semaforo_sequenciador
  import semaforo_pkg::*;
#(
  parameter int unsigned T_VERDE_MIN = T_VERDE_MIN_DEF,
  parameter int unsigned T_AMARELO   = T_AMARELO_DEF,
  parameter int unsigned T_VERMELHO  = T_VERMELHO_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sa,
  input  logic       sb,
  output logic       verde_a,
  output logic       amarelo_a,
  output logic       vermelho_a,
  output logic       verde_b,
  output logic       amarelo_b,
  output logic       vermelho_b,
  output logic [2:0] fase
);
  localparam logic [7:0] LIM_V  = 8'(T_VERDE_MIN - 1);
  localparam logic [7:0] LIM_AM = 8'(T_AMARELO - 1);
  localparam logic [7:0] LIM_VM = 8'(T_VERMELHO - 1);
  fase_e      state_q, state_d;
  logic [7:0] limit, cnt;
  logic       done, verde, clear, min_ok;
  semaforo_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .sat_en (verde),
    .limit  (limit),
    .cnt    (cnt),
    .done   (done)
  );
  always_comb begin
    verde   = state_q == VERDE_A || state_q == VERDE_B;
    limit   = verde ? LIM_V : (state_q == AMARELO_A || state_q == AMARELO_B) ? LIM_AM : LIM_VM;
    min_ok  = cnt == LIM_V;
    state_d = VERMELHO_BA;
    case (state_q)
      VERDE_A:     state_d = (min_ok && sb && !sa) ? AMARELO_A : VERDE_A;
      AMARELO_A:   state_d = done ? VERMELHO_AB : AMARELO_A;
      VERMELHO_AB: state_d = done ? VERDE_B : VERMELHO_AB;
      VERDE_B:     state_d = (min_ok && sa && !sb) ? AMARELO_B : VERDE_B;
      AMARELO_B:   state_d = done ? VERMELHO_BA : AMARELO_B;
      VERMELHO_BA: state_d = done ? VERDE_A : VERMELHO_BA;
      default:     state_d = VERMELHO_BA;
    endcase
    clear = state_d != state_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= VERMELHO_BA;
    else     state_q <= state_d;
  // Red is the complement of green/yellow, so illegal codes still light exactly one lamp per street
  assign verde_a    = state_q == VERDE_A;
  assign amarelo_a  = state_q == AMARELO_A;
  assign vermelho_a = !verde_a && !amarelo_a;
  assign verde_b    = state_q == VERDE_B;
  assign amarelo_b  = state_q == AMARELO_B;
  assign vermelho_b = !verde_b && !amarelo_b;
  assign fase       = state_q;
endmodule

// File: tb/tb_semaforo_sequenciador.sv
// tb_semaforo_sequenciador: phase-table reference model plus directed and random request stimulus
module tb_semaforo_sequenciador;
  logic clk = 1'b0, rst = 1'b1, sa = 1'b0, sb = 1'b0;
  logic verde_a, amarelo_a, vermelho_a, verde_b, amarelo_b, vermelho_b;
  logic [2:0] fase;
  int errors = 0, checks = 0;
  int mp = 5, mt = 0;
  int dur [6] = '{8, 3, 2, 8, 3, 2};

  semaforo_sequenciador dut (
    .clk(clk), .rst(rst), .sa(sa), .sb(sb),
    .verde_a(verde_a), .amarelo_a(amarelo_a), .vermelho_a(vermelho_a),
    .verde_b(verde_b), .amarelo_b(amarelo_b), .vermelho_b(vermelho_b),
    .fase(fase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Phases run 0..5 in a ring; greens wait for minimum time plus an exclusive cross request
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mp <= 5;
      mt <= 0;
    end else if (mp == 0 || mp == 3) begin
      if (mt + 1 >= dur[mp] && (mp == 0 ? (sb && !sa) : (sa && !sb))) begin
        mp <= mp + 1;
        mt <= 0;
      end else mt <= mt + 1;
    end else if (mt + 1 >= dur[mp]) begin
      mp <= (mp + 1) % 6;
      mt <= 0;
    end else mt <= mt + 1;
  end

  always @(negedge clk) begin
    chk("fase", int'(fase), mp);
    chk("verde_a", int'(verde_a), int'(mp == 0));
    chk("amarelo_a", int'(amarelo_a), int'(mp == 1));
    chk("vermelho_a", int'(vermelho_a), int'(mp >= 2));
    chk("verde_b", int'(verde_b), int'(mp == 3));
    chk("amarelo_b", int'(amarelo_b), int'(mp == 4));
    chk("vermelho_b", int'(vermelho_b), int'(mp != 3 && mp != 4));
    chk("one_lamp_a", int'(verde_a) + int'(amarelo_a) + int'(vermelho_a), 1);
    chk("one_lamp_b", int'(verde_b) + int'(amarelo_b) + int'(vermelho_b), 1);
    chk("no_dual_green", int'(verde_a && verde_b), 0);
  end

  initial begin
    int hold;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rel_f0", int'(fase), 5);
    @(negedge clk) chk("rel_f1", int'(fase), 5);
    @(negedge clk) chk("rel_f2", int'(fase), 0);
    repeat (20) begin
      @(negedge clk);
      chk("hold_fase", int'(fase), 0);
      chk("hold_va", int'(verde_a), 1);
      chk("hold_vb", int'(vermelho_b), 1);
    end
    sb = 1'b1;
    repeat (3) @(negedge clk) chk("seq_am_a", int'(fase), 1);
    repeat (2) @(negedge clk) chk("seq_vm_ab", int'(fase), 2);
    @(negedge clk) chk("seq_vd_b", int'(fase), 3);
    sa = 1'b1;
    repeat (60) @(negedge clk) chk("both_hold_b", int'(fase), 3);
    sb = 1'b0;
    @(negedge clk) chk("to_am_b", int'(fase), 4);
    #2 rst = 1'b1;
    #1;
    chk("arst_fase", int'(fase), 5);
    chk("arst_red", int'({verde_a, amarelo_a, vermelho_a, verde_b, amarelo_b, vermelho_b}), 6'b001001);
    @(negedge clk);
    rst = 1'b0;
    sa = 1'b0;
    chk("arel_f0", int'(fase), 5);
    @(negedge clk) chk("arel_f1", int'(fase), 5);
    @(negedge clk) chk("arel_f2", int'(fase), 0);
    sb = 1'b1;
    for (int i = 1; i <= 7; i++) @(negedge clk) chk("min_green", int'(fase), 0);
    @(negedge clk) chk("min_green_exit", int'(fase), 1);
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 599) == 0) rst = 1'b1;
      if (hold == 0) begin
        sa = 1'($urandom_range(0, 1));
        sb = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 14);
      end else hold--;
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
